// File: rtl/key_event_sched.sv
// Keyboard change events -> press/release event FIFO with typematic-repeat suppression and LED toggle.
// Optional feature: define KEY_RELEASE_EVT_EN to also enqueue release events (release_flag = evt_data[9]).
module key_event_sched #(
  parameter int         FIFO_DEPTH  = 4,
  parameter logic [8:0] TOGGLE_CODE = 9'h058
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_valid,
  input  logic [511:0] key_down,
  input  logic [8:0]   last_change,
  input  logic         evt_ready,
  input  logic         ovf_clr,
  output logic         evt_valid,
  output logic [9:0]   evt_data,
  output logic [4:0]   evt_count,
  output logic         overflow,
  output logic         led_state
);

  // state   | meaning
  // EMPTY   | no events queued, evt_valid low
  // PARTIAL | 1..FIFO_DEPTH-1 events queued
  // FULL    | FIFO_DEPTH events queued; a push without a same-cycle pop is dropped
  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } q_state_t;

  localparam int         AW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [4:0] DEPTH_CNT = 5'(FIFO_DEPTH);
`ifdef KEY_RELEASE_EVT_EN
  localparam int EW = 10;
`else
  localparam int EW = 9;
`endif

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [4:0]    count;
  logic [4:0]    count_nxt;
  q_state_t      state;
  q_state_t      state_nxt;

  logic          lock_valid;
  logic [8:0]    lock_code;

  logic          key_is_down;
  logic          press_det;
  logic          release_det;
  logic          lock_hit;
  logic          press_acc;
  logic          push_req;
  logic          pop;
  logic          push;
  logic          drop;
  logic          full;
  logic [EW-1:0] push_entry;

  assign key_is_down = key_down[last_change];
  assign press_det   = key_valid & key_is_down;
  assign release_det = key_valid & ~key_is_down;
  assign lock_hit    = lock_valid & (lock_code == last_change);
  assign press_acc   = press_det & ~lock_hit;

`ifdef KEY_RELEASE_EVT_EN
  assign push_req   = press_acc | release_det;
  assign push_entry = {release_det, last_change};
`else
  assign push_req   = press_acc;
  assign push_entry = last_change;
`endif

  // A pop frees the slot for a same-cycle push, so a full queue only drops without one.
  assign pop  = evt_valid & evt_ready;
  assign push = push_req & (~full | pop);
  assign drop = push_req & full & ~pop;

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 5'd1;
      2'b01:   count_nxt = count - 5'd1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      count <= count_nxt;
      if (push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_valid <= 1'b0;
      lock_code  <= '0;
    end else if (press_acc) begin
      lock_valid <= 1'b1;
      lock_code  <= last_change;
    end else if (release_det && lock_hit) begin
      lock_valid <= 1'b0;
    end
  end

  // Toggle follows acceptance, not enqueue: a dropped toggle press still flips the LED.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_state <= 1'b0;
    end else if (press_acc && (last_change == TOGGLE_CODE)) begin
      led_state <= ~led_state;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = PARTIAL;
    if (count_nxt == 5'd0)           state_nxt = EMPTY;
    else if (count_nxt >= DEPTH_CNT) state_nxt = FULL;
  end

  always_comb begin
    evt_valid = 1'b0;
    full      = 1'b0;
    case (state)
      EMPTY:   begin evt_valid = 1'b0; full = 1'b0; end
      PARTIAL: begin evt_valid = 1'b1; full = 1'b0; end
      FULL:    begin evt_valid = 1'b1; full = 1'b1; end
      default: begin evt_valid = 1'b0; full = 1'b0; end
    endcase
  end

  assign evt_count = count;
`ifdef KEY_RELEASE_EVT_EN
  assign evt_data = mem[rd_ptr];
`else
  assign evt_data = {1'b0, mem[rd_ptr]};
`endif

endmodule

// File: tb/tb_key_event_sched.sv
// Self-checking bench for key_event_sched: directed scenarios plus randomized traffic against a queue model.
module tb_key_event_sched;
  localparam int         DEPTH = 4;
  localparam logic [8:0] TOG   = 9'h058;
`ifdef KEY_RELEASE_EVT_EN
  localparam bit REL_EN = 1'b1;
`else
  localparam bit REL_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         key_valid = 1'b0;
  logic [511:0] key_down = '0;
  logic [8:0]   last_change = '0;
  logic         evt_ready = 1'b0;
  logic         ovf_clr = 1'b0;
  logic         evt_valid;
  logic [9:0]   evt_data;
  logic [4:0]   evt_count;
  logic         overflow;
  logic         led_state;

  int errors = 0;
  int checks = 0;

  logic [9:0] mq[$];
  logic [9:0] dut_popped[$];
  logic       m_lock_v;
  logic [8:0] m_lock;
  logic       m_ovf;
  logic       m_led;

  key_event_sched #(.FIFO_DEPTH(DEPTH), .TOGGLE_CODE(TOG)) dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_down(key_down),
    .last_change(last_change), .evt_ready(evt_ready), .ovf_clr(ovf_clr),
    .evt_valid(evt_valid), .evt_data(evt_data), .evt_count(evt_count),
    .overflow(overflow), .led_state(led_state)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    mq.delete();
    m_lock_v = 1'b0;
    m_lock   = '0;
    m_ovf    = 1'b0;
    m_led    = 1'b0;
  endtask

  // Reference behaviour of one clock edge, written from the event rules.
  task automatic model_step(input bit kv, input logic [8:0] code, input bit down,
                            input bit rdy, input bit clr);
    bit was_full, do_pop, push_req, dropped;
    logic [9:0] ev;
    was_full = (mq.size() == DEPTH);
    do_pop   = (mq.size() > 0) && rdy;
    push_req = 1'b0;
    ev       = '0;
    if (kv && down) begin
      if (!(m_lock_v && m_lock == code)) begin
        m_lock_v = 1'b1;
        m_lock   = code;
        if (code == TOG) m_led = ~m_led;
        push_req = 1'b1;
        ev       = {1'b0, code};
      end
    end else if (kv && !down) begin
      if (m_lock_v && m_lock == code) m_lock_v = 1'b0;
      if (REL_EN) begin
        push_req = 1'b1;
        ev       = {1'b1, code};
      end
    end
    if (do_pop) void'(mq.pop_front());
    dropped = push_req && was_full && !do_pop;
    if (push_req && !dropped) mq.push_back(ev);
    if (dropped) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
  endtask

  task automatic drive(input bit kv, input logic [8:0] code, input bit down,
                       input bit rdy, input bit clr);
    for (int i = 0; i < 16; i++) key_down[i*32 +: 32] = $urandom;
    key_down[code] = down;
    key_valid   = kv;
    last_change = code;
    evt_ready   = rdy;
    ovf_clr     = clr;
    @(negedge clk);
    if (evt_valid && evt_ready) dut_popped.push_back(evt_data);
    @(posedge clk);
    model_step(kv, code, down, rdy, clr);
    #1;
    key_valid = 1'b0;
    evt_ready = 1'b0;
    ovf_clr   = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 20 && mq.size() > 0; n++) drive(1'b0, 9'h000, 1'b0, 1'b1, 1'b0);
    checks++;
    if (evt_count !== 5'd0 || evt_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain: count=%0d valid=%b required count=0 valid=0", evt_count, evt_valid);
    end
  endtask

  task automatic test_reset();
    // Event pulse held through reset must be lost.
    key_down = '0;
    key_down[9'h01C] = 1'b1;
    last_change = 9'h01C;
    key_valid = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({evt_valid, evt_count, evt_data, overflow, led_state} !== 18'd0) begin
      errors++;
      $display("FAIL reset_state: valid=%b count=%0d data=%h ovf=%b led=%b required all 0",
               evt_valid, evt_count, evt_data, overflow, led_state);
    end
    @(negedge clk);
    key_valid = 1'b0;
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    checks++;
    if (evt_count !== 5'd0) begin
      errors++;
      $display("FAIL reset_pulse_lost: count=%0d required 0", evt_count);
    end
    drive(1'b1, 9'h011, 1'b1, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (evt_count !== 5'd0 || evt_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: count=%0d valid=%b required 0 0", evt_count, evt_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic test_press_latency();
    key_down = '0;
    key_down[9'h01C] = 1'b1;
    last_change = 9'h01C;
    key_valid = 1'b1;
    #1;
    checks++;
    if (evt_valid !== 1'b0) begin
      errors++;
      $display("FAIL press_before_edge: valid=%b required 0", evt_valid);
    end
    drive(1'b1, 9'h01C, 1'b1, 1'b0, 1'b0);
    checks++;
    if (evt_valid !== 1'b1 || evt_data !== 10'h01C || evt_count !== 5'd1) begin
      errors++;
      $display("FAIL press_latency: valid=%b data=%h count=%0d required 1 01c 1",
               evt_valid, evt_data, evt_count);
    end
    // Release while popping the press: with release events enabled it replaces the head.
    drive(1'b1, 9'h01C, 1'b0, 1'b1, 1'b0);
    checks++;
    if (REL_EN) begin
      if (evt_count !== 5'd1 || evt_data !== 10'h21C) begin
        errors++;
        $display("FAIL release_evt: count=%0d data=%h required 1 21c", evt_count, evt_data);
      end
    end else begin
      if (evt_count !== 5'd0 || evt_valid !== 1'b0) begin
        errors++;
        $display("FAIL release_no_evt: count=%0d valid=%b required 0 0", evt_count, evt_valid);
      end
    end
    drain();
  endtask

  task automatic test_toggle();
    int n;
    dut_popped.delete();
    drive(1'b1, TOG, 1'b1, 1'b0, 1'b0);
    checks++;
    if (led_state !== 1'b1) begin
      errors++;
      $display("FAIL toggle_first: led=%b required 1", led_state);
    end
    drive(1'b1, TOG, 1'b0, 1'b1, 1'b0);
    drive(1'b1, TOG, 1'b1, 1'b0, 1'b0);
    checks++;
    if (led_state !== 1'b0) begin
      errors++;
      $display("FAIL toggle_second: led=%b required 0", led_state);
    end
    drive(1'b1, TOG, 1'b0, 1'b1, 1'b0);
    drain();
    n = 0;
    foreach (dut_popped[i]) begin
      if (dut_popped[i][9] == 1'b0) begin
        n++;
        checks++;
        if (dut_popped[i] !== {1'b0, TOG}) begin
          errors++;
          $display("FAIL toggle_deq_code: got %h required %h", dut_popped[i], {1'b0, TOG});
        end
      end
    end
    checks++;
    if (n != 2) begin
      errors++;
      $display("FAIL toggle_deq_count: got %0d press events required 2", n);
    end
  endtask

  task automatic test_repeat();
    logic led0;
    led0 = led_state;
    drive(1'b1, 9'h023, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 9'h023, 1'b1, 1'b0, 1'b0);
    checks++;
    if (evt_count !== 5'd1 || evt_data !== 10'h023 || led_state !== led0) begin
      errors++;
      $display("FAIL repeat_suppress: count=%0d data=%h led=%b required 1 023 %b",
               evt_count, evt_data, led_state, led0);
    end
    drive(1'b1, 9'h023, 1'b0, 1'b1, 1'b0);
    drain();
    drive(1'b1, TOG, 1'b1, 1'b0, 1'b0);
    drive(1'b1, TOG, 1'b1, 1'b0, 1'b0);
    checks++;
    if (led_state !== ~led0 || evt_count !== 5'd1) begin
      errors++;
      $display("FAIL repeat_toggle: led=%b count=%0d required %b 1", led_state, evt_count, ~led0);
    end
    drive(1'b1, TOG, 1'b0, 1'b1, 1'b0);
    drain();
  endtask

  task automatic test_overflow();
    logic [9:0] exp[4] = '{10'h001, 10'h002, 10'h003, 10'h004};
    dut_popped.delete();
    for (int i = 1; i <= 4; i++) drive(1'b1, 9'(i), 1'b1, 1'b0, 1'b0);
    checks++;
    if (evt_count !== 5'd4 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL fill: count=%0d ovf=%b required 4 0", evt_count, overflow);
    end
    drive(1'b1, 9'h005, 1'b1, 1'b0, 1'b0);
    checks++;
    if (evt_count !== 5'd4 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_drop: count=%0d ovf=%b required 4 1", evt_count, overflow);
    end
    drive(1'b1, 9'h006, 1'b1, 1'b0, 1'b1);
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_clr_vs_drop: ovf=%b required 1", overflow);
    end
    drive(1'b0, 9'h000, 1'b0, 1'b0, 1'b1);
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clr: ovf=%b required 0", overflow);
    end
    drain();
    checks++;
    if (dut_popped.size() != 4) begin
      errors++;
      $display("FAIL overflow_deq_count: got %0d required 4", dut_popped.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (dut_popped[i] !== exp[i]) begin
          errors++;
          $display("FAIL overflow_order[%0d]: got %h required %h", i, dut_popped[i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_full_push_pop();
    logic [9:0] exp[7] = '{10'h011, 10'h012, 10'h013, 10'h014, 10'h015, 10'h016, 10'h017};
    dut_popped.delete();
    for (int i = 0; i < 4; i++) drive(1'b1, 9'h011 + 9'(i), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 9'h015 + 9'(i), 1'b1, 1'b1, 1'b0);
      checks++;
      if (evt_count !== 5'd4 || overflow !== 1'b0) begin
        errors++;
        $display("FAIL full_push_pop[%0d]: count=%0d ovf=%b required 4 0", i, evt_count, overflow);
      end
    end
    drain();
    checks++;
    if (dut_popped.size() != 7) begin
      errors++;
      $display("FAIL wrap_deq_count: got %0d required 7", dut_popped.size());
    end else begin
      for (int i = 0; i < 7; i++) begin
        checks++;
        if (dut_popped[i] !== exp[i]) begin
          errors++;
          $display("FAIL wrap_order[%0d]: got %h required %h", i, dut_popped[i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [8:0] pool[6] = '{9'h058, 9'h01C, 9'h023, 9'h1FF, 9'h000, 9'h0A5};
    logic [8:0] code;
    for (int n = 0; n < 600; n++) begin
      code = ($urandom_range(0, 7) == 0) ? 9'($urandom) : pool[$urandom_range(0, 5)];
      drive($urandom_range(0, 1) == 1, code, $urandom_range(0, 2) != 0,
            $urandom_range(0, 9) < 4, $urandom_range(0, 9) == 0);
      checks++;
      if (evt_valid !== (mq.size() != 0) || evt_count !== 5'(mq.size()) ||
          overflow !== m_ovf || led_state !== m_led ||
          (mq.size() != 0 && evt_data !== mq[0])) begin
        errors++;
        $display("FAIL random[%0d]: valid=%b count=%0d ovf=%b led=%b data=%h required %b %0d %b %b %h",
                 n, evt_valid, evt_count, overflow, led_state, evt_data,
                 mq.size() != 0, mq.size(), m_ovf, m_led, (mq.size() != 0) ? mq[0] : 10'h000);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_press_latency();
    test_toggle();
    test_repeat();
    test_overflow();
    test_full_push_pop();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
